// File: rtl/seq_detect_param.sv
// Serial pattern detector built on a KMP-style prefix automaton.
// The state is the length of the longest pattern prefix that ends the
// consumed bit stream. Every transition is resolved while the design is
// elaborated, so the hardware is a small constant lookup, the state
// register, a registered match pulse and a saturating match counter.
module seq_detect_param #(
   parameter int N = 4,
   parameter logic [N-1:0] PATTERN = 4'b1101,
   parameter int OVERLAP = 1,
   parameter int CNT_W = 8,
   localparam int SW = $clog2(N + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             x,
   input  logic             en,
   input  logic             clr_count,
   output logic             match,
   output logic [SW-1:0]    state,
   output logic [CNT_W-1:0] match_count
);

   // Pattern bit idx, where idx = N-1 is the first bit expected on the wire.
   function automatic logic patBit(input int idx);
      logic [N-1:0] shifted;
      shifted = PATTERN >> idx;
      return shifted[0];
   endfunction

   // Bit t of the string formed by the k-bit matched prefix followed by b.
   function automatic logic streamBit(input int k, input logic b, input int t);
      logic result;
      if (t < k) begin
         result = patBit(N - 1 - t);
      end else begin
         result = b;
      end
      return result;
   endfunction

   // Successor of state k on input b: the longest pattern prefix that is a
   // suffix of (prefix_k, b), capped at N. A completed match in
   // non-overlapping mode discards all history except the new bit.
   function automatic logic [SW-1:0] nextState(input int k, input logic b);
      int   best;
      logic ok;
      best = 0;
      if (OVERLAP == 0 && k == N) begin
         best = (b == patBit(N - 1)) ? 1 : 0;
      end else begin
         for (int l = 1; l <= k + 1; l++) begin
            if (l <= N) begin
               ok = 1'b1;
               for (int i = 0; i < l; i++) begin
                  if (streamBit(k, b, k + 1 - l + i) != patBit(N - 1 - i)) begin
                     ok = 1'b0;
                  end
               end
               if (ok) begin
                  best = l;
               end
            end
         end
      end
      return SW'(best);
   endfunction

   logic [SW-1:0]    nextOnZero [N+1];
   logic [SW-1:0]    nextOnOne  [N+1];

   logic [SW-1:0]    state_q;
   logic [SW-1:0]    state_d;
   logic             match_q;
   logic             match_d;
   logic [CNT_W-1:0] matchCount_q;
   logic [CNT_W-1:0] matchCount_d;

   // Elaboration-time transition table, one entry per state for each input bit.
   for (genvar k = 0; k <= N; k++) begin : g_next
      localparam logic [SW-1:0] NextZero = nextState(k, 1'b0);
      localparam logic [SW-1:0] NextOne  = nextState(k, 1'b1);
      assign nextOnZero[k] = NextZero;
      assign nextOnOne[k]  = NextOne;
   end

   // Next state, match pulse and counter update; clear beats a simultaneous increment.
   always_comb begin
      state_d      = state_q;
      match_d      = 1'b0;
      matchCount_d = matchCount_q;
      if (en) begin
         state_d = x ? nextOnOne[state_q] : nextOnZero[state_q];
         match_d = (state_d == SW'(N));
      end
      if (clr_count) begin
         matchCount_d = '0;
      end else if (match_d && (matchCount_q != {CNT_W{1'b1}})) begin
         matchCount_d = matchCount_q + CNT_W'(1);
      end
   end

   // State, pulse and counter registers; reset wipes any partial match at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= '0;
         match_q      <= 1'b0;
         matchCount_q <= '0;
      end else begin
         state_q      <= state_d;
         match_q      <= match_d;
         matchCount_q <= matchCount_d;
      end
   end

   assign state       = state_q;
   assign match       = match_q;
   assign match_count = matchCount_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: three instances (overlapping, non-overlapping,
// 2-bit counter) share one stimulus stream and are compared against a
// string-matching reference model after every clock edge.
module tb_seq_detect_param;

   localparam int N = 4;
   localparam logic [N-1:0] PAT = 4'b1101;
   localparam int SW = $clog2(N + 1);

   logic          clk;
   logic          reset;
   logic          x;
   logic          en;
   logic          clr_count;
   logic          matchA;
   logic          matchB;
   logic          matchC;
   logic [SW-1:0] stateA;
   logic [SW-1:0] stateB;
   logic [SW-1:0] stateC;
   logic [7:0]    countA;
   logic [7:0]    countB;
   logic [1:0]    countC;

   int compared;
   int mismatched;

   bit          modelOverlap [3] = '{1'b1, 1'b0, 1'b1};
   int          modelMax     [3] = '{255, 255, 3};
   int          modelState   [3];
   bit          modelMatch   [3];
   int          modelCount   [3];
   logic [31:0] histBits     [3];
   int          histLen      [3];

   seq_detect_param #(.N(N), .PATTERN(PAT), .OVERLAP(1), .CNT_W(8)) dutA (
      .clk(clk), .reset(reset), .x(x), .en(en), .clr_count(clr_count),
      .match(matchA), .state(stateA), .match_count(countA)
   );

   seq_detect_param #(.N(N), .PATTERN(PAT), .OVERLAP(0), .CNT_W(8)) dutB (
      .clk(clk), .reset(reset), .x(x), .en(en), .clr_count(clr_count),
      .match(matchB), .state(stateB), .match_count(countB)
   );

   seq_detect_param #(.N(N), .PATTERN(PAT), .OVERLAP(1), .CNT_W(2)) dutC (
      .clk(clk), .reset(reset), .x(x), .en(en), .clr_count(clr_count),
      .match(matchC), .state(stateC), .match_count(countC)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Longest pattern prefix that is a suffix of the recorded history (newest bit at h[0]).
   function automatic int refState(input logic [31:0] h, input int len);
      int best;
      bit ok;
      best = 0;
      for (int l = 1; l <= N && l <= len; l++) begin
         ok = 1'b1;
         for (int i = 0; i < l; i++) begin
            if (h[l-1-i] != PAT[N-1-i]) ok = 1'b0;
         end
         if (ok) best = l;
      end
      return best;
   endfunction

   task automatic modelReset();
      for (int j = 0; j < 3; j++) begin
         modelState[j] = 0;
         modelMatch[j] = 1'b0;
         modelCount[j] = 0;
         histBits[j]   = '0;
         histLen[j]    = 0;
      end
   endtask

   task automatic modelStep(input logic xv, input logic ev, input logic cv);
      for (int j = 0; j < 3; j++) begin
         if (ev) begin
            histBits[j] = {histBits[j][30:0], xv};
            if (histLen[j] < 32) histLen[j]++;
            modelState[j] = refState(histBits[j], histLen[j]);
            modelMatch[j] = (modelState[j] == N);
            if (modelMatch[j] && !modelOverlap[j]) histLen[j] = 0;
         end else begin
            modelMatch[j] = 1'b0;
         end
         if (cv) modelCount[j] = 0;
         else if (modelMatch[j] && modelCount[j] < modelMax[j]) modelCount[j]++;
      end
   endtask

   task automatic checkOne(input string tag, input logic [SW-1:0] obsState,
                           input logic obsMatch, input logic [7:0] obsCount, input int j);
      logic [SW-1:0] expState;
      logic          expMatch;
      logic [7:0]    expCount;
      expState = SW'(modelState[j]);
      expMatch = modelMatch[j];
      expCount = 8'(modelCount[j]);
      compared++;
      assert (obsState === expState) else begin
         mismatched++;
         $error("[TB] FAIL %s.state observed=%0d expected=%0d", tag, obsState, expState);
      end
      compared++;
      assert (obsMatch === expMatch) else begin
         mismatched++;
         $error("[TB] FAIL %s.match observed=%0b expected=%0b", tag, obsMatch, expMatch);
      end
      compared++;
      assert (obsCount === expCount) else begin
         mismatched++;
         $error("[TB] FAIL %s.match_count observed=%0d expected=%0d", tag, obsCount, expCount);
      end
   endtask

   task automatic checkOutput(input string tag);
      checkOne({tag, "/A"}, stateA, matchA, countA, 0);
      checkOne({tag, "/B"}, stateB, matchB, countB, 1);
      checkOne({tag, "/C"}, stateC, matchC, {6'b0, countC}, 2);
   endtask

   task automatic checkConst(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drives one cycle of inputs, lets one rising edge pass, then checks 1 time unit later.
   task automatic applyStimulus(input logic xv, input logic ev, input logic cv);
      x         = xv;
      en        = ev;
      clr_count = cv;
      @(posedge clk);
      modelStep(xv, ev, cv);
      #1;
      checkOutput("step");
   endtask

   // Pulses reset between clock edges and checks the outputs cleared without a clock.
   task automatic applyReset();
      #1;
      reset = 1'b1;
      #1;
      modelReset();
      checkOutput("reset");
      #1;
      reset = 1'b0;
   endtask

   task automatic feedStream(input logic [31:0] bits, input int len);
      for (int i = len - 1; i >= 0; i--) begin
         applyStimulus(bits[i], 1'b1, 1'b0);
      end
   endtask

   initial begin
      reset      = 1'b1;
      x          = 1'b0;
      en         = 1'b0;
      clr_count  = 1'b0;
      compared   = 0;
      mismatched = 0;
      modelReset();
      @(posedge clk);
      #1;
      applyReset();
      checkConst("resetStateA", {5'b0, stateA}, 8'd0);

      $display("[TB] basic 1101");
      feedStream(32'b1101, 4);
      checkConst("basicStateA", {5'b0, stateA}, 8'd4);
      checkConst("basicMatchA", {7'b0, matchA}, 8'd1);
      checkConst("basicCountA", countA, 8'd1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkConst("basicPulseEndA", {7'b0, matchA}, 8'd0);

      $display("[TB] overlap stream 1101101");
      applyReset();
      feedStream(32'b1101101, 7);
      checkConst("overlapCountA", countA, 8'd2);
      checkConst("noOverlapCountB", countB, 8'd1);

      $display("[TB] failure transition 11101");
      applyReset();
      feedStream(32'b11101, 5);
      checkConst("failStateA", {5'b0, stateA}, 8'd4);
      checkConst("failCountA", countA, 8'd1);

      $display("[TB] enable gaps");
      applyReset();
      for (int i = 3; i >= 0; i--) begin
         applyStimulus(PAT[i], 1'b1, 1'b0);
         applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b0);
         applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
      checkConst("gapStateA", {5'b0, stateA}, 8'd4);
      checkConst("gapCountA", countA, 8'd1);

      $display("[TB] saturating 2-bit counter");
      applyReset();
      feedStream(32'b1101101101101, 13);
      checkConst("satCountC", {6'b0, countC}, 8'd3);
      feedStream(32'b10, 2);
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkConst("clrMatchC", {7'b0, matchC}, 8'd1);
      checkConst("clrCountC", {6'b0, countC}, 8'd0);

      $display("[TB] mid-sequence reset");
      applyReset();
      feedStream(32'b110, 3);
      applyReset();
      checkConst("midResetStateA", {5'b0, stateA}, 8'd0);
      feedStream(32'b1101, 4);
      checkConst("midResetCountA", countA, 8'd1);

      $display("[TB] random stream");
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            applyReset();
         end else begin
            applyStimulus(1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 19) == 0));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
